// File: rtl/sevga_scanout_if.sv
// sevga_scanout_if: VRAM fetch port between the raster engine and the VRAM arbiter.
// master = raster engine (issues fetches, reports CPU write slot), slave = arbiter.
interface sevga_scanout_if #(
  parameter int ADDR_W = 16
);
  logic              vramRdReq;
  logic [ADDR_W-1:0] vramAddr;
  logic [7:0]        vramData;
  logic              writeSlot;

  modport master (output vramRdReq, vramAddr, writeSlot, input vramData);
  modport slave  (input vramRdReq, vramAddr, writeSlot, output vramData);
endinterface

// File: rtl/sevga_scanout.sv
// sevga_scanout: SE-VGA raster engine. Generates syncs, sequences VRAM byte fetches
// one fetch group ahead of the beam and serialises bytes MSB-first, H_SCALE clocks per bit.
// Optional feature: define SCANOUT_BORDER_EN to draw a white 1-pixel frame on the
// outermost columns/lines of the image window (fetching is unaffected).
module sevga_scanout #(
  parameter int H_ACTIVE = 1024,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 136,
  parameter int H_BP     = 160,
  parameter int V_ACTIVE = 768,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 6,
  parameter int V_BP     = 29,
  parameter int SRC_W    = 512,
  parameter int SRC_H    = 342,
  parameter int H_SCALE  = 2,
  parameter int V_SCALE  = 2,
  parameter int PAGES    = 2,
  parameter int READ_LAT = 3,
  localparam int COL_W   = $clog2(SRC_W / 8),
  localparam int ROW_W   = $clog2(SRC_H),
  localparam int PG_W    = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int ADDR_W  = PG_W + ROW_W + COL_W
) (
  input  logic            pixClk,
  input  logic            reset,
  input  logic [PG_W-1:0] pageSel,
  sevga_scanout_if.master vram,
  output logic            nhSync,
  output logic            nvSync,
  output logic            vidOut,
  output logic            frameStart
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int GRP      = 8 * H_SCALE;
  localparam int NBYTES   = SRC_W / 8;
  localparam int WIN_W    = (SRC_W * H_SCALE < H_ACTIVE) ? SRC_W * H_SCALE : H_ACTIVE;
  localparam int WIN_H    = (SRC_H * V_SCALE < V_ACTIVE) ? SRC_H * V_SCALE : V_ACTIVE;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int K0_H     = H_TOTAL - GRP;
  localparam int HC_W     = $clog2(H_TOTAL);
  localparam int VC_W     = $clog2(V_TOTAL);
  localparam int GT_W     = $clog2(GRP);
  localparam int GI_W     = $clog2(H_TOTAL / GRP + 2);
  localparam int PT_W     = (H_SCALE > 1) ? $clog2(H_SCALE) : 1;
  localparam int RP_W     = (V_SCALE > 1) ? $clog2(V_SCALE) : 1;

  logic [HC_W-1:0]     hCount;
  logic [VC_W-1:0]     vCount;
  logic [GT_W-1:0]     grpTimer;
  logic [GI_W-1:0]     grpIdx;
  logic [PT_W-1:0]     pixTimer;
  logic [2:0]          bitIdx;
  logic [ROW_W-1:0]    rowCnt;
  logic [RP_W-1:0]     repTimer;
  logic [PG_W-1:0]     pageReg;
  logic [READ_LAT-1:0] latPipe;
  logic [7:0]          holdReg;
  logic [7:0]          shiftReg;

  logic              hWrap, vWrap, groupStart, lineInWin, nextInWin, inWin;
  logic              reqK0, reqNext, pixBit, pixNext;
  logic [ROW_W-1:0]  nextRow;
  logic [ADDR_W-1:0] addrNext;
  logic [7:0]        curByte;

  // Beam position decode, fetch scheduling and next pixel value.
  always_comb begin
    hWrap      = hCount == HC_W'(H_TOTAL - 1);
    vWrap      = vCount == VC_W'(V_TOTAL - 1);
    groupStart = grpTimer == GT_W'(GRP - 1);
    lineInWin  = vCount < VC_W'(WIN_H);
    // The line after V_TOTAL-1 is line 0, which is always inside the window.
    nextInWin  = vWrap || (vCount < VC_W'(WIN_H - 1));
    nextRow    = vWrap ? '0 : ((repTimer == '0) ? rowCnt + 1'b1 : rowCnt);
    reqK0      = (hCount == HC_W'(K0_H)) && nextInWin;
    reqNext    = reqK0 || (groupStart && lineInWin && (grpIdx < GI_W'(NBYTES - 1)));
    addrNext   = reqK0 ? {pageReg, nextRow, COL_W'(0)}
                       : {pageReg, rowCnt, COL_W'(grpIdx + 1'b1)};
    // At a group boundary the new byte is still in holdReg; shiftReg takes it this edge.
    curByte    = groupStart ? holdReg : shiftReg;
    pixBit     = curByte[bitIdx];
    inWin      = lineInWin && (hCount < HC_W'(WIN_W));
`ifdef SCANOUT_BORDER_EN
    pixNext    = inWin && (~pixBit || (hCount == '0) || (hCount == HC_W'(WIN_W - 1)) ||
                           (vCount == '0) || (vCount == VC_W'(WIN_H - 1)));
`else
    pixNext    = inWin && ~pixBit;
`endif
  end

  // Raster counters; vCount steps on the same clock hCount wraps.
  always_ff @(posedge pixClk) begin
    if (reset) begin
      hCount <= '0;
      vCount <= '0;
    end else if (hWrap) begin
      hCount <= '0;
      vCount <= vWrap ? '0 : vCount + 1'b1;
    end else begin
      hCount <= hCount + 1'b1;
    end
  end

  // Fetch-group and bit-phase down-counters, realigned at every line start.
  always_ff @(posedge pixClk) begin
    if (reset || hWrap) begin
      grpTimer <= GT_W'(GRP - 1);
      grpIdx   <= '0;
      pixTimer <= PT_W'(H_SCALE - 1);
      bitIdx   <= 3'd7;
    end else begin
      if (pixTimer == '0) begin
        pixTimer <= PT_W'(H_SCALE - 1);
        bitIdx   <= bitIdx - 1'b1;
      end else begin
        pixTimer <= pixTimer - 1'b1;
      end
      if (grpTimer == '0) begin
        grpTimer <= GT_W'(GRP - 1);
        grpIdx   <= grpIdx + 1'b1;
      end else begin
        grpTimer <= grpTimer - 1'b1;
      end
    end
  end

  // Source row of the current line, repeated V_SCALE lines each.
  always_ff @(posedge pixClk) begin
    if (reset) begin
      rowCnt   <= '0;
      repTimer <= RP_W'(V_SCALE - 1);
    end else if (hWrap) begin
      if (vWrap || repTimer == '0) repTimer <= RP_W'(V_SCALE - 1);
      else                         repTimer <= repTimer - 1'b1;
      rowCnt <= nextRow;
    end
  end

  // Display page latched as vertical sync starts, so a frame never mixes pages.
  always_ff @(posedge pixClk) begin
    if (reset) pageReg <= '0;
    else if (hCount == '0 && vCount == VC_W'(VS_START)) pageReg <= pageSel;
  end

  // Fetch strobe, read-latency tracking and byte hold/shift registers.
  always_ff @(posedge pixClk) begin
    if (reset) begin
      vram.vramRdReq <= 1'b0;
      vram.vramAddr  <= '0;
      latPipe        <= '0;
      holdReg        <= '0;
      shiftReg       <= '0;
    end else begin
      vram.vramRdReq <= reqNext;
      vram.vramAddr  <= reqNext ? addrNext : '0;
      latPipe        <= (latPipe << 1) | READ_LAT'(vram.vramRdReq);
      if (latPipe[READ_LAT-1]) holdReg <= vram.vramData;
      if (groupStart) shiftReg <= holdReg;
    end
  end

  // VRAM is busy from the strobe clock through the capture clock.
  assign vram.writeSlot = ~(vram.vramRdReq | (|latPipe));

  // Monitor-facing outputs, all one clock behind the counters.
  always_ff @(posedge pixClk) begin
    if (reset) begin
      nhSync     <= 1'b1;
      nvSync     <= 1'b1;
      vidOut     <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      nhSync     <= !((hCount >= HC_W'(HS_START)) && (hCount < HC_W'(HS_END)));
      nvSync     <= !((vCount >= VC_W'(VS_START)) && (vCount < VC_W'(VS_END)));
      vidOut     <= pixNext;
      frameStart <= (hCount == '0) && (vCount == '0);
    end
  end

endmodule
